mux_rr_arbiter: RTL

Round-robin arbiter that shares one N:1 data mux between N requesters. It drives the mux select, registers a one-hot grant per requester and enforces a maximum ownership time so that no requester can starve the others. It sits in front of the shared mux datapath and is the only block allowed to drive its select.

---
 rtl/mux_rr_arbiter_pkg.sv | 7 +
 rtl/mux_rr_arbiter_rr_pick.sv | 18 +
 rtl/mux_rr_arbiter.sv | 63 ++++++
 3 files changed

// File: rtl/mux_rr_arbiter_pkg.sv
// mux_arb_pkg: shared state type and select-width helper for the round-robin mux arbiter.
package mux_arb_pkg;
  typedef enum logic {IDLE, OWN} arb_state_t;
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// rr_pick: finds the first set candidate bit searching upward from last+1, wrapping at N-1.
module rr_pick #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  cand_i,
  input  logic [SW-1:0] last_i,
  output logic          found_o,
  output logic [SW-1:0] idx_o
);
  always_comb begin
    found_o = |cand_i;
    idx_o = '0;
    // Scan farthest offset first so the nearest candidate after last overwrites it.
    for (int k = N; k >= 1; k--)
      if (cand_i[(int'(last_i) + k) % N]) idx_o = SW'((int'(last_i) + k) % N);
  end
endmodule

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin owner of a shared N:1 data mux with a bounded hold time.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N-1:0]              req,
  input  logic [N*DATA_W-1:0]       data_in,
  output logic [N-1:0]              grant,
  output logic [sel_width(N)-1:0]   sel,
  output logic [DATA_W-1:0]         data_out,
  output logic                      busy
);
  localparam int SW = sel_width(N);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  arb_state_t    state_q;
  logic [N-1:0]  grant_q;
  logic [SW-1:0] sel_q, last_q, w;
  logic [HW-1:0] hold_q;
  logic          busy_q, own_req, sat, found, take;
  logic [N-1:0]  cand;
  assign own_req = req[sel_q];
  assign sat     = hold_q == HW'(MAX_HOLD - 1);
  // While owning, the picker only ever sees the other requesters.
  assign cand    = (state_q == IDLE) ? req : (req & ~(N'(1) << sel_q));
  assign take    = found && (state_q == IDLE || !own_req || sat);
  rr_pick #(.N(N), .SW(SW)) u_pick (
    .cand_i  (cand),
    .last_i  (last_q),
    .found_o (found),
    .idx_o   (w)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      last_q  <= SW'(N - 1);
      hold_q  <= '0;
    end else if (take) begin
      state_q <= OWN;
      grant_q <= N'(1) << w;
      sel_q   <= w;
      busy_q  <= 1'b1;
      last_q  <= w;
      hold_q  <= '0;
    end else if (state_q == OWN && !own_req) begin
      state_q <= IDLE;
      grant_q <= '0;
      busy_q  <= 1'b0;
    end else if (state_q == OWN && !sat) begin
      hold_q  <= hold_q + 1'b1;
    end
  assign grant    = grant_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign data_out = busy_q ? data_in[sel_q*DATA_W +: DATA_W] : '0;
endmodule
